bridge_arbiter_2: RTL
=====================

Name: bridge_arbiter_2

Overview:
- Two-master arbiter that shares one 32-bit host port of the 32-to-16 bridge between two requesters, for example the instruction fetch and data ports of the CPU.
- Each master presents a 32-bit transaction (cs, addr, wdata, wr_en, bytesel) and holds it until it sees its own compl.
- The arbiter picks one master, muxes its request onto the downstream port and returns registered read data and completion to that master only.
- It inserts a release cycle after each completion so the downstream port never sees stale requests.

Parameters:
FIXED_PRIORITY, 0, 0 = round-robin between masters; 1 = master 0 always wins a simultaneous request.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
m0_cs  in  1  master 0 chip select
m0_addr  in  32  master 0 address
m0_wdata  in  32  master 0 write data
m0_wr_en  in  1  master 0 write enable
m0_bytesel  in  4  master 0 byte enables
m0_rdata  out  32  master 0 read data, registered
m0_compl  out  1  master 0 completion pulse, registered
m1_cs, m1_addr, m1_wdata, m1_wr_en, m1_bytesel, m1_rdata, m1_compl  same as m0_*, for master 1
s_cs  out  1  downstream chip select
s_addr  out  32  downstream address
s_wdata  out  32  downstream write data
s_wr_en  out  1  downstream write enable
s_bytesel  out  4  downstream byte enables
s_rdata  in  32  downstream read data, valid when s_compl=1
s_compl  in  1  downstream completion pulse
grant  out  2  one-hot current owner, 2'b00 when none

Behaviour:
- Request definition: mX_req = mX_cs && |mX_bytesel. A cs with bytesel=0 is not a request and is never granted.
- Reset (rst_n=0 at a rising edge): state=IDLE, grant=00, last-served pointer=master 1 (so master 0 wins the first tie).
  - m0_rdata, m1_rdata = 0; m0_compl, m1_compl = 0.
  - s_cs=0, s_addr=0, s_wdata=0, s_wr_en=0, s_bytesel=0.
- States: IDLE, OWN0, OWN1, RELEASE.
- IDLE:
  - s_* outputs all 0.
  - No request: stay in IDLE.
  - Exactly one request: go to OWNx for that master.
  - Both requesting with FIXED_PRIORITY=1: go to OWN0.
  - Both requesting with FIXED_PRIORITY=0: grant the master that is not the last-served one.
- OWNx:
  - grant is one-hot for x.
  - s_cs, s_addr, s_wdata, s_wr_en and s_bytesel are combinationally muxed from master x.
  - On s_compl=1: capture s_rdata into mX_rdata (reads only; write completions leave mX_rdata unchanged), set the last-served pointer to x, go to RELEASE.
- RELEASE:
  - s_* outputs forced to 0 and grant=00.
  - mX_compl=1 for exactly this cycle, for the master just served.
  - Unconditionally go to IDLE.
- Latency, from a request sampled in IDLE at cycle N:
  - s_cs is high at N+1.
  - s_compl at cycle M gives mX_compl at M+1.
  - The earliest next grant is visible at M+3 (IDLE at M+2).
- mX_rdata holds its value until that master's next read completion. mX_compl is never high for both masters in the same cycle.
- s_compl outside OWN0/OWN1 is ignored: no pulse, no state change.
- Master withdraws cs while owning: the arbiter stays in OWNx until s_compl. Masters must hold their requests until compl; this is a protocol violation, not recovered.
- Non-requesting master: its inputs do not affect s_* and its rdata/compl do not change.
- Reset mid-transaction: the arbiter returns to IDLE at once and s_cs drops on the next cycle. Software must hold rst_n low at least 6 cycles so the bridge drains; any late s_compl is ignored per the rule above.
- The s_* mux is combinational from registered grant state plus master inputs. No combinational path from s_compl to s_* or mX_compl.

Test Plan:
1. Reset, then m0 read of addr 0x100, bytesel=4'hF. Downstream returns s_rdata=0xDEADBEEF with s_compl at cycle 5 -> s_cs high cycles 1..5; m0_compl=1 at cycle 6 only; m0_rdata=0xDEADBEEF; m1_compl stays 0.
2. m0 and m1 request in the same cycle, FIXED_PRIORITY=0, and both keep requesting -> grants alternate m0, m1, m0, m1 over 4 transactions; grant sequence 01, 10, 01, 10 with a 00 gap of 2 cycles between them.
3. Same stimulus with FIXED_PRIORITY=1 and both masters re-requesting -> m0 served every time; m1 starved.
4. m1 write with wdata=0x12345678, bytesel=4'h3 -> s_wdata=0x12345678, s_bytesel=4'h3, s_wr_en=1 while OWN1; m1_rdata unchanged after m1_compl.
5. m0_cs=1 with bytesel=0 for 10 cycles -> state stays IDLE, s_cs=0, no compl. A spurious s_compl pulse in IDLE produces no mX_compl.
6. rst_n driven low during OWN0 -> next cycle all outputs are 0 and grant=00. A late s_compl is ignored, and a fresh m1 request after reset is granted normally.

Source files
------------

// File: rtl/bridge_arbiter_2.sv
// Two-master arbiter in front of the 32-bit host port of the 32-to-16 bridge.
// One master owns the downstream port until its s_compl arrives. A RELEASE
// cycle then drives the port idle so no stale request is seen downstream.
module bridge_arbiter_2 #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_cs,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_wr_en,
  input  logic [3:0]  m0_bytesel,
  output logic [31:0] m0_rdata,
  output logic        m0_compl,
  input  logic        m1_cs,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_wr_en,
  input  logic [3:0]  m1_bytesel,
  output logic [31:0] m1_rdata,
  output logic        m1_compl,
  output logic        s_cs,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic        s_wr_en,
  output logic [3:0]  s_bytesel,
  input  logic [31:0] s_rdata,
  input  logic        s_compl,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, RELEASE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;      // last-served master, 1 = master 1
  logic [31:0] r_m0_rdata;
  logic [31:0] r_m1_rdata;
  logic        r_m0_compl;
  logic        r_m1_compl;

  // A chip select with no byte lanes enabled is not a request.
  logic w_req0;
  logic w_req1;
  assign w_req0 = m0_cs && (|m0_bytesel);
  assign w_req1 = m1_cs && (|m1_bytesel);

  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;
  assign m0_compl = r_m0_compl;
  assign m1_compl = r_m1_compl;

  // Next-state selection and downstream mux driven from the registered owner.
  always_comb begin
    w_next    = r_state;
    grant     = 2'b00;
    s_cs      = 1'b0;
    s_addr    = 32'h0;
    s_wdata   = 32'h0;
    s_wr_en   = 1'b0;
    s_bytesel = 4'h0;
    unique case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) begin
          if (FIXED_PRIORITY) w_next = OWN0;
          else                w_next = r_last ? OWN0 : OWN1;
        end else if (w_req0) begin
          w_next = OWN0;
        end else if (w_req1) begin
          w_next = OWN1;
        end
      end
      OWN0: begin
        grant     = 2'b01;
        s_cs      = m0_cs;
        s_addr    = m0_addr;
        s_wdata   = m0_wdata;
        s_wr_en   = m0_wr_en;
        s_bytesel = m0_bytesel;
        if (s_compl) w_next = RELEASE;
      end
      OWN1: begin
        grant     = 2'b10;
        s_cs      = m1_cs;
        s_addr    = m1_addr;
        s_wdata   = m1_wdata;
        s_wr_en   = m1_wr_en;
        s_bytesel = m1_bytesel;
        if (s_compl) w_next = RELEASE;
      end
      RELEASE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, round-robin pointer, captured read data and completion pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_m0_rdata <= 32'h0;
      r_m1_rdata <= 32'h0;
      r_m0_compl <= 1'b0;
      r_m1_compl <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_m0_compl <= (r_state == OWN0) && s_compl;
      r_m1_compl <= (r_state == OWN1) && s_compl;
      if ((r_state == OWN0) && s_compl) begin
        r_last <= 1'b0;
        if (!m0_wr_en) r_m0_rdata <= s_rdata;
      end
      if ((r_state == OWN1) && s_compl) begin
        r_last <= 1'b1;
        if (!m1_wr_en) r_m1_rdata <= s_rdata;
      end
    end
  end

endmodule
